// File: rtl/win3x3_gen_pkg.sv
// Shared constants for the 3x3 window generator: default geometry,
// window slot indices and counter-width helpers.
package win3x3_gen_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned COLS_DEF  = 640;
  localparam int unsigned ROWS_DEF  = 480;

  // Slot k = 3*ry + cx; ry 0 is the oldest row, cx 0 the leftmost column.
  localparam int unsigned SLOT_TL = 0;
  localparam int unsigned SLOT_T  = 1;
  localparam int unsigned SLOT_TR = 2;
  localparam int unsigned SLOT_L  = 3;
  localparam int unsigned SLOT_C  = 4;
  localparam int unsigned SLOT_R  = 5;
  localparam int unsigned SLOT_BL = 6;
  localparam int unsigned SLOT_B  = 7;
  localparam int unsigned SLOT_BR = 8;
  localparam int unsigned NSLOT   = 9;

  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CB_DEF = cnt_bits(COLS_DEF);
  localparam int unsigned RB_DEF = cnt_bits(ROWS_DEF);

endpackage

// File: rtl/win3x3_gen_row_delay.sv
// Single-row delay line: circular RAM, read-before-write, so the output is
// exactly the sample accepted DEPTH enables earlier.
module row_delay
  import win3x3_gen_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = COLS_DEF,
  parameter int unsigned AB    = cnt_bits(COLS_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AB-1:0]    ptr;

  // RAM contents are never cleared; the window gate masks stale data.
  assign dout = mem[ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (ena) begin
      ptr <= (ptr == AB'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ena) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/win3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two row delays feed a 3x3 shift
// window; outputs are registered and gated to complete in-image windows.
module win3x3_gen
  import win3x3_gen_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned COLS  = COLS_DEF,
  parameter int unsigned ROWS  = ROWS_DEF,
  parameter int unsigned CB    = CB_DEF,
  parameter int unsigned RB    = RB_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [WIDTH-1:0]   dat_in,
  output logic [9*WIDTH-1:0] win_out,
  output logic               win_val,
  output logic [CB-1:0]      col_out,
  output logic [RB-1:0]      row_out,
  output logic               eof
);

  logic [CB-1:0]                 col;
  logic [RB-1:0]                 row;
  logic [WIDTH-1:0]              lb0_q;
  logic [WIDTH-1:0]              lb1_q;
  logic [NSLOT-1:0][WIDTH-1:0]   win_q;
  logic                          col_last;
  logic                          row_last;
  logic                          in_img;

  assign col_last = (col == CB'(COLS - 1));
  assign row_last = (row == RB'(ROWS - 1));
  assign in_img   = (col >= CB'(2)) && (row >= RB'(2));

  row_delay #(
    .WIDTH (WIDTH),
    .DEPTH (COLS),
    .AB    (CB)
  ) u_lb0 (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .din  (dat_in),
    .dout (lb0_q)
  );

  row_delay #(
    .WIDTH (WIDTH),
    .DEPTH (COLS),
    .AB    (CB)
  ) u_lb1 (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .din  (lb0_q),
    .dout (lb1_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (ena) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q <= '0;
    end else if (ena) begin
      for (int unsigned ry = 0; ry < 3; ry++) begin
        win_q[3*ry]     <= win_q[3*ry + 1];
        win_q[3*ry + 1] <= win_q[3*ry + 2];
      end
      win_q[SLOT_TR] <= lb1_q;
      win_q[SLOT_R]  <= lb0_q;
      win_q[SLOT_BR] <= dat_in;
    end
  end

  assign win_out = win_q;

  // Centre coordinates only move with a valid window, so they hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_val <= 1'b0;
      eof     <= 1'b0;
      col_out <= '0;
      row_out <= '0;
    end else begin
      win_val <= ena && in_img;
      eof     <= ena && row_last && col_last;
      if (ena && in_img) begin
        col_out <= col - 1'b1;
        row_out <= row - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_win3x3_gen.sv
// Bench for win3x3_gen on an 8x6 frame with pixel = 16*row + col; an image
// store model predicts every output cycle, plus pinned literal windows.
module tb_win3x3_gen;

  localparam int W   = 8;
  localparam int C   = 8;
  localparam int R   = 6;
  localparam int CBT = 3;
  localparam int RBT = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ena = 1'b0;
  logic [W-1:0]     dat_in = '0;
  logic [9*W-1:0]   win_out;
  logic             win_val;
  logic [CBT-1:0]   col_out;
  logic [RBT-1:0]   row_out;
  logic             eof;

  win3x3_gen #(
    .WIDTH (W),
    .COLS  (C),
    .ROWS  (R),
    .CB    (CBT),
    .RB    (RBT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .dat_in  (dat_in),
    .win_out (win_out),
    .win_val (win_val),
    .col_out (col_out),
    .row_out (row_out),
    .eof     (eof)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    vectors++;
    if (act !== 32'(exp)) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remembers every accepted pixel by image position.
  int img [R][C];
  int mr = 0, mc = 0;
  bit exp_val = 0, exp_eof = 0;
  int exp_col = 0, exp_row = 0;
  int exp_win [9];
  bit win_known = 1;
  int dut_pulses = 0, dut_eofs = 0;

  task automatic model_reset();
    mr = 0; mc = 0;
    exp_val = 0; exp_eof = 0;
    exp_col = 0; exp_row = 0;
    for (int k = 0; k < 9; k++) exp_win[k] = 0;
    win_known = 1;
  endtask

  task automatic model_step(input bit e, input int d);
    if (e) begin
      img[mr][mc] = d;
      exp_eof = (mr == R-1) && (mc == C-1);
      if (mr >= 2 && mc >= 2) begin
        exp_val = 1;
        exp_col = mc - 1;
        exp_row = mr - 1;
        for (int k = 0; k < 9; k++) exp_win[k] = img[mr-2+k/3][mc-2+k%3];
        win_known = 1;
      end else begin
        exp_val = 0;
        win_known = 0;
      end
      if (mc == C-1) begin
        mc = 0;
        mr = (mr == R-1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end else begin
      exp_val = 0;
      exp_eof = 0;
    end
  endtask

  always @(negedge clk) begin
    chk("win_val", 32'(win_val), int'(exp_val));
    chk("eof", 32'(eof), int'(exp_eof));
    chk("col_out", 32'(col_out), exp_col);
    chk("row_out", 32'(row_out), exp_row);
    if (win_known)
      for (int k = 0; k < 9; k++)
        chk($sformatf("slot%0d", k), 32'(win_out[W*k +: W]), exp_win[k]);
    if (win_val === 1'b1) dut_pulses++;
    if (eof === 1'b1) dut_eofs++;
  end

  int dr = 0, dc = 0;

  task automatic px(input bit e);
    int sr;
    int sc;
    sr = dr;
    sc = dc;
    ena = e;
    dat_in = e ? W'(16*dr + dc) : W'($urandom);
    @(posedge clk);
    model_step(e, 16*sr + sc);
    if (e) begin
      if (dc == C-1) begin
        dc = 0;
        dr = (dr == R-1) ? 0 : dr + 1;
      end else begin
        dc++;
      end
    end
    #1;
    if (e) begin
      if (sr == 2 && sc == 2) begin
        chk("first_slot0", 32'(win_out[7:0]), 'h00);
        chk("first_slot4", 32'(win_out[39:32]), 'h11);
        chk("first_slot8", 32'(win_out[71:64]), 'h22);
        chk("first_col", 32'(col_out), 1);
        chk("first_row", 32'(row_out), 1);
      end
      if (sr == 3 && sc < 2) chk("row3_edge_val", 32'(win_val), 0);
      if (sr == 3 && sc == 2) begin
        chk("row3_slot0", 32'(win_out[7:0]), 'h10);
        chk("row3_slot8", 32'(win_out[71:64]), 'h32);
      end
      if (sr == R-1 && sc == C-1) begin
        chk("eof_pulse", 32'(eof), 1);
        chk("eof_col", 32'(col_out), 6);
        chk("eof_row", 32'(row_out), 4);
        chk("eof_slot8", 32'(win_out[71:64]), 'h57);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit e;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // one continuous frame
    dut_pulses = 0; dut_eofs = 0;
    repeat (C*R) px(1'b1);
    px(1'b0);
    chk("frame1_pulses", 32'(dut_pulses), 24);
    chk("frame1_eofs", 32'(dut_eofs), 1);

    // two back-to-back frames
    dut_pulses = 0; dut_eofs = 0;
    repeat (2*C*R) px(1'b1);
    px(1'b0);
    chk("b2b_pulses", 32'(dut_pulses), 48);
    chk("b2b_eofs", 32'(dut_eofs), 2);

    // one frame with random enable gaps
    dut_pulses = 0; dut_eofs = 0;
    n = 0;
    for (int i = 0; i < 2000 && n < C*R; i++) begin
      e = ($urandom_range(0, 9) < 4);
      px(e);
      if (e) n++;
    end
    px(1'b0);
    chk("gap_pixels", 32'(n), C*R);
    chk("gap_pulses", 32'(dut_pulses), 24);
    chk("gap_eofs", 32'(dut_eofs), 1);

    // asynchronous reset after (3,4)
    repeat (3*C + 5) px(1'b1);
    ena = 1'b0;
    #1 rst = 1'b0;
    model_reset();
    dr = 0; dc = 0;
    #1;
    chk("rst_win_val", 32'(win_val), 0);
    chk("rst_eof", 32'(eof), 0);
    chk("rst_col", 32'(col_out), 0);
    chk("rst_row", 32'(row_out), 0);
    for (int k = 0; k < 9; k++)
      chk($sformatf("rst_slot%0d", k), 32'(win_out[W*k +: W]), 0);
    @(posedge clk);
    #2 rst = 1'b1;

    dut_pulses = 0; dut_eofs = 0;
    repeat (C*R) px(1'b1);
    px(1'b0);
    chk("post_rst_pulses", 32'(dut_pulses), 24);
    chk("post_rst_eofs", 32'(dut_eofs), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
